// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back / write-allocate cache between a requester bus (rx)
// and a memory bus (tx), with round-robin replacement and a full-cache FLUSH operation.
module set_assoc_cache #(
   parameter int ADDR_WIDTH  = 6,
   parameter int DATA_WIDTH  = 8,
   parameter int INDEX_WIDTH = 2,
   parameter int WAYS        = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            rx_req_op,
   input  logic [ADDR_WIDTH-1:0] rx_req_addr,
   input  logic [DATA_WIDTH-1:0] rx_req_data,
   output logic                  rx_req_rdy,
   output logic                  rx_rsp_vld,
   output logic [DATA_WIDTH-1:0] rx_rsp_data,
   output logic                  tx_rst,
   output logic [1:0]            tx_req_op,
   output logic [ADDR_WIDTH-1:0] tx_req_addr,
   output logic [DATA_WIDTH-1:0] tx_req_data,
   input  logic                  tx_rsp_vld,
   input  logic [DATA_WIDTH-1:0] tx_rsp_data
);

   localparam int SETS      = 1 << INDEX_WIDTH;
   localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
   localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int ENTRIES   = SETS * WAYS;
   localparam int ENT_W     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   localparam logic [1:0] OP_INV = 2'd0;
   localparam logic [1:0] OP_RD  = 2'd1;
   localparam logic [1:0] OP_WR  = 2'd2;
   localparam logic [1:0] OP_FL  = 2'd3;

   localparam logic [1:0] ST_INV   = 2'd0;
   localparam logic [1:0] ST_CLEAN = 2'd1;
   localparam logic [1:0] ST_DIRTY = 2'd2;

   typedef enum logic [1:0] {S_READY, S_WRITEBACK, S_FILL, S_FLUSH} state_t;

   // line storage
   logic [1:0]            stat_q [SETS][WAYS];
   logic [TAG_WIDTH-1:0]  tag_q  [SETS][WAYS];
   logic [DATA_WIDTH-1:0] line_q [SETS][WAYS];
   logic [WAY_W-1:0]      rr_q   [SETS];

   state_t                state_q, state_d;
   logic [ENT_W-1:0]      cnt_q, cnt_d;
   logic [1:0]            op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [WAY_W-1:0]      victim_q;

   logic                  rsp_vld_q, rsp_vld_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  tx_rst_q;
   logic [1:0]            tx_op_q, tx_op_d;
   logic [ADDR_WIDTH-1:0] tx_addr_q, tx_addr_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

   logic [INDEX_WIDTH-1:0] req_idx, addr_idx, fl_set, we_set;
   logic [TAG_WIDTH-1:0]   req_tag, we_tag;
   logic [WAY_W-1:0]       hit_way, inv_way, victim, fl_way, we_way, rr_nxt;
   logic                   hit, inv_found;
   logic                   latch_en, line_we, stat_we, rr_we;
   logic [1:0]             we_stat;
   logic [DATA_WIDTH-1:0]  we_data;

   assign req_idx  = rx_req_addr[INDEX_WIDTH-1:0];
   assign req_tag  = rx_req_addr[ADDR_WIDTH-1:INDEX_WIDTH];
   assign addr_idx = addr_q[INDEX_WIDTH-1:0];
   assign fl_set   = INDEX_WIDTH'(cnt_q / ENT_W'(WAYS));
   assign fl_way   = WAY_W'(cnt_q % ENT_W'(WAYS));
   assign rr_nxt   = WAY_W'((32'(victim_q) + 32'd1) % WAYS);

   // Descending scan so the lowest-numbered matching / invalid way wins.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (stat_q[req_idx][w] != ST_INV && tag_q[req_idx][w] == req_tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (stat_q[req_idx][w] == ST_INV) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
      victim = inv_found ? inv_way : rr_q[req_idx];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rsp_vld_d  = 1'b0;
      rsp_data_d = rsp_data_q;
      tx_op_d    = OP_INV;
      tx_addr_d  = tx_addr_q;
      tx_data_d  = tx_data_q;
      latch_en   = 1'b0;
      line_we    = 1'b0;
      stat_we    = 1'b0;
      rr_we      = 1'b0;
      we_set     = req_idx;
      we_way     = hit_way;
      we_stat    = ST_CLEAN;
      we_tag     = req_tag;
      we_data    = rx_req_data;
      case (state_q)
         S_READY: begin
            if (rx_req_op != OP_INV) begin
               latch_en = 1'b1;
               if (rx_req_op == OP_FL) begin
                  state_d = S_FLUSH;
                  cnt_d   = '0;
               end else if (hit) begin
                  if (rx_req_op == OP_RD) begin
                     rsp_vld_d  = 1'b1;
                     rsp_data_d = line_q[req_idx][hit_way];
                  end else begin
                     line_we = 1'b1;
                     we_stat = ST_DIRTY;
                  end
               end else if (stat_q[req_idx][victim] == ST_DIRTY) begin
                  tx_op_d   = OP_WR;
                  tx_addr_d = {tag_q[req_idx][victim], req_idx};
                  tx_data_d = line_q[req_idx][victim];
                  state_d   = S_WRITEBACK;
               end else begin
                  tx_op_d   = OP_RD;
                  tx_addr_d = rx_req_addr;
                  state_d   = S_FILL;
               end
            end
         end
         S_WRITEBACK: begin
            tx_op_d   = OP_RD;
            tx_addr_d = addr_q;
            state_d   = S_FILL;
         end
         S_FILL: begin
            if (tx_rsp_vld) begin
               line_we = 1'b1;
               rr_we   = 1'b1;
               we_set  = addr_idx;
               we_way  = victim_q;
               we_tag  = addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
               if (op_q == OP_WR) begin
                  we_stat = ST_DIRTY;
                  we_data = wdata_q;
               end else begin
                  we_stat    = ST_CLEAN;
                  we_data    = tx_rsp_data;
                  rsp_vld_d  = 1'b1;
                  rsp_data_d = tx_rsp_data;
               end
               state_d = S_READY;
            end
         end
         S_FLUSH: begin
            we_set = fl_set;
            we_way = fl_way;
            if (stat_q[fl_set][fl_way] == ST_DIRTY) begin
               tx_op_d   = OP_WR;
               tx_addr_d = {tag_q[fl_set][fl_way], fl_set};
               tx_data_d = line_q[fl_set][fl_way];
               stat_we   = 1'b1;
               we_stat   = ST_CLEAN;
            end
            if (cnt_q == ENT_W'(ENTRIES - 1)) begin
               rsp_vld_d  = 1'b1;
               rsp_data_d = '0;
               state_d    = S_READY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_READY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_READY;
         cnt_q      <= '0;
         op_q       <= OP_INV;
         addr_q     <= '0;
         wdata_q    <= '0;
         victim_q   <= '0;
         rsp_vld_q  <= 1'b0;
         rsp_data_q <= '0;
         tx_rst_q   <= 1'b1;
         tx_op_q    <= OP_INV;
         tx_addr_q  <= '0;
         tx_data_q  <= '0;
         for (int s = 0; s < SETS; s++) begin
            rr_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) stat_q[s][w] <= ST_INV;
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_data_q <= rsp_data_d;
         tx_rst_q   <= 1'b0;
         tx_op_q    <= tx_op_d;
         tx_addr_q  <= tx_addr_d;
         tx_data_q  <= tx_data_d;
         if (latch_en) begin
            op_q     <= rx_req_op;
            addr_q   <= rx_req_addr;
            wdata_q  <= rx_req_data;
            victim_q <= victim;
         end
         if (line_we || stat_we) stat_q[we_set][we_way] <= we_stat;
         if (rr_we) rr_q[addr_idx] <= rr_nxt;
      end
   end

   // Tag/data need no reset: a line is only trusted once its status leaves INVALID.
   always_ff @(posedge clk) begin
      if (line_we) begin
         tag_q[we_set][we_way]  <= we_tag;
         line_q[we_set][we_way] <= we_data;
      end
   end

   assign rx_req_rdy  = (state_q == S_READY);
   assign rx_rsp_vld  = rsp_vld_q;
   assign rx_rsp_data = rsp_data_q;
   assign tx_rst      = tx_rst_q;
   assign tx_req_op   = tx_op_q;
   assign tx_req_addr = tx_addr_q;
   assign tx_req_data = tx_data_q;

endmodule

// File: doc/set_assoc_cache.md
# set_assoc_cache

Parametrised N-way set-associative write-back, write-allocate cache that sits between a requester-side memory bus (rx) and a memory-side bus (tx). It generalises the direct-mapped cache with configurable ways, deterministic victim selection, a ready signal for upstream back-pressure, and a FLUSH operation that writes back every dirty line. Op encoding: 2'd0 INVALID, 2'd1 READ, 2'd2 WRITE, 2'd3 FLUSH.

## Interface
- ADDR_WIDTH, 6, byte-less word address width
- DATA_WIDTH, 8, data word width
- INDEX_WIDTH, 2, set index width; SETS = 1<<INDEX_WIDTH; TAG_WIDTH = ADDR_WIDTH-INDEX_WIDTH
- WAYS, 2, associativity, power of two, 1..8
- clk  in  1  clock
- rst  in  1  synchronous active-high reset; one clock; reset is synchronous and active-high
- rx_req_op  in  2  upstream request op
- rx_req_addr  in  ADDR_WIDTH  upstream address
- rx_req_data  in  DATA_WIDTH  upstream write data
- rx_req_rdy  out  1  high when a request will be accepted (state READY)
- rx_rsp_vld  out  1  one-cycle pulse: read data or flush completion
- rx_rsp_data  out  DATA_WIDTH  read data; 0 on flush completion
- tx_rst  out  1  one-cycle pulse the cycle after rst
- tx_req_op  out  2  memory request op (READ/WRITE only), one-cycle pulse
- tx_req_addr  out  ADDR_WIDTH  memory address
- tx_req_data  out  DATA_WIDTH  writeback data
- tx_rsp_vld  in  1  memory read response valid
- tx_rsp_data  in  DATA_WIDTH  memory read data

## Operation
- Per line: status {INVALID, CLEAN, DIRTY}, tag, data. Per set: round-robin pointer rr (log2 WAYS bits).
- index = addr[INDEX_WIDTH-1:0]; tag = addr[ADDR_WIDTH-1:INDEX_WIDTH].
- States: READY, WRITEBACK, FILL, FLUSH.
- READY, rx_req_op != INVALID: latch op/addr/data.
  - Hit (non-INVALID way with matching tag): READ -> rx_rsp_vld=1 with the line data; WRITE -> line data replaced, status DIRTY, no response; stay READY.
  - Miss: victim = lowest-numbered INVALID way in set, else way rr[index]. Victim DIRTY -> tx WRITE {victim tag, index} with victim data, go WRITEBACK. Otherwise -> tx READ of the request address, go FILL.
  - FLUSH -> go FLUSH, scan counter = 0.
- WRITEBACK: tx READ of the latched address; go FILL.
- FILL: wait for tx_rsp_vld. Install {CLEAN, tag, tx_rsp_data} in victim; rr[index] <= victim+1 mod WAYS. READ -> rx_rsp_vld=1, rx_rsp_data=tx_rsp_data. WRITE -> data = latched data, DIRTY, no response. Go READY.
- FLUSH: one entry per cycle, entry e = set e/WAYS, way e%WAYS. DIRTY entry -> tx WRITE {tag, set} data, status CLEAN. After entry SETS*WAYS-1: rx_rsp_vld=1, rx_rsp_data=0, go READY. Lines stay valid.
- Requests with rx_req_rdy low are ignored; upstream holds until rdy.
- tx_rsp_vld outside FILL is ignored.
- Reset (any state, incl. mid-FILL/FLUSH): all lines INVALID, all rr = 0, state READY, pending operation abandoned, late memory responses ignored, tx_rst=1 next cycle.

## Timing
- All outputs registered except rx_req_rdy = (state == READY).
- Reset values: rx_rsp_vld 0, rx_rsp_data 0, tx_rst 0 (1 the cycle after rst), tx_req_op INVALID, tx_req_addr 0, tx_req_data 0; rx_req_rdy 1 after reset.
- Read hit: rx_rsp_vld 1 cycle after request cycle; back-to-back hits sustain one per cycle.
- Clean miss: tx READ 1 cycle after request; rx_rsp_vld 1 cycle after tx_rsp_vld.
- Dirty miss: tx WRITE at +1, tx READ at +2.
- Flush: rx_rsp_vld at SETS*WAYS+1 cycles after request; tx WRITEs appear in scan order.
- tx_req_op is INVALID in every cycle not issuing a request.

## Test plan
Config ADDR 6, DATA 8, INDEX 2, WAYS 2; memory returns read data 3 cycles after request.
- Reset, READ 0x05, memory returns 0x3C -> tx READ 0x05, rx_rsp 0x3C; re-READ 0x05 -> rx_rsp 0x3C 1 cycle later, no tx traffic.
- READ 0x01, 0x05, then 0x09 (set 1) -> first two fill ways 0,1; 0x09 evicts way 0; READ 0x05 hits, READ 0x01 misses.
- WRITE 0x02=0xAA, 0x06=0xBB, 0x0A=0xCC -> third write: tx WRITE 0x02/0xAA, next cycle tx READ 0x0A; no rx_rsp for writes.
- Then FLUSH -> tx WRITE 0x0A/0xCC (set 2 way 0) then 0x06/0xBB, rx_rsp_vld with data 0 at cycle 9; second FLUSH -> no tx WRITEs, rsp at cycle 9.
- READ 0x07, assert rst while in FILL, then memory responds -> response ignored, no rx_rsp, tx_rst pulse; READ 0x07 misses again.
- Request presented while rx_req_rdy low (during FILL) and dropped -> no tx or rx activity for it.
